// File: rtl/ifmap_stream_feeder.sv
`default_nettype none
// ============================================================================
// Module      : ifmap_stream_feeder
// Description : Reads a row-major IFMap tile from synchronous memory and
//               streams {end_of_map, end_of_row, pixel} words into the PE
//               IFMap FIFO through a 2-entry skid buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module ifmap_stream_feeder #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  row_len,
    input  logic [LEN_WIDTH-1:0]  num_rows,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_ren,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  fifo_full,
    output logic                  fifo_wen,
    output logic [DATA_WIDTH+1:0] fifo_wdata
);

    localparam int c_WORD_W = DATA_WIDTH + 2;
    localparam int c_CNT_W  = 2 * LEN_WIDTH;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_FIN  = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [LEN_WIDTH-1:0]  r_row_len;
    logic [LEN_WIDTH-1:0]  r_col;
    logic [c_CNT_W-1:0]    r_total;
    logic [c_CNT_W-1:0]    r_issued;
    logic                  r_inflight;
    logic                  r_inf_eor;
    logic                  r_inf_eom;
    logic [c_WORD_W-1:0]   r_skid0;
    logic [c_WORD_W-1:0]   r_skid1;
    logic [1:0]            r_skid_cnt;

    logic                  w_pop;
    logic                  w_ren;
    logic                  w_eor;
    logic                  w_eom;
    logic [2:0]            w_occ;
    logic [c_WORD_W-1:0]   w_new;
    logic [c_CNT_W-1:0]    w_product;

    // A word leaving this cycle frees its slot, so a read may still issue
    // when the buffer looks full; this keeps one word per cycle sustained.
    assign w_pop     = (r_skid_cnt != 2'd0) && !fifo_full;
    assign w_occ     = {1'b0, r_skid_cnt} - {2'b00, w_pop} + {2'b00, r_inflight};
    assign w_ren     = (r_state == c_ST_RUN) && (r_issued < r_total) && (w_occ < 3'd2);
    assign w_eor     = (r_col == r_row_len - LEN_WIDTH'(1));
    assign w_eom     = (r_issued == r_total - c_CNT_W'(1));
    assign w_product = c_CNT_W'(row_len) * c_CNT_W'(num_rows);
    assign w_new     = {r_inf_eom, r_inf_eor, mem_rdata};

    assign mem_ren    = w_ren;
    assign mem_addr   = w_ren ? (r_base + ADDR_WIDTH'(r_issued)) : '0;
    assign fifo_wen   = w_pop;
    assign fifo_wdata = r_skid0;
    assign busy       = (r_state != c_ST_IDLE);
    assign done       = (r_state == c_ST_FIN);

    // Emptiness is judged on the latched size, one cycle after start.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (start) w_state_nxt = c_ST_RUN;
            c_ST_RUN:  if ((r_total == '0) || (w_pop && r_skid0[c_WORD_W-1]))
                           w_state_nxt = c_ST_FIN;
            c_ST_FIN:  w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= c_ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_base    <= '0;
            r_row_len <= '0;
            r_total   <= '0;
            r_issued  <= '0;
            r_col     <= '0;
        end else if ((r_state == c_ST_IDLE) && start) begin
            r_base    <= base_addr;
            r_row_len <= row_len;
            r_total   <= w_product;
            r_issued  <= '0;
            r_col     <= '0;
        end else if (w_ren) begin
            r_issued <= r_issued + c_CNT_W'(1);
            r_col    <= w_eor ? '0 : r_col + LEN_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_inflight <= 1'b0;
            r_inf_eor  <= 1'b0;
            r_inf_eom  <= 1'b0;
        end else begin
            r_inflight <= w_ren;
            r_inf_eor  <= w_ren & w_eor;
            r_inf_eom  <= w_ren & w_eom;
        end
    end

    // Entry 0 is the head and reads as zero whenever the buffer is empty.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_skid0    <= '0;
            r_skid1    <= '0;
            r_skid_cnt <= 2'd0;
        end else begin
            case ({r_inflight, w_pop})
                2'b10: begin
                    if (r_skid_cnt == 2'd0) r_skid0 <= w_new;
                    else                    r_skid1 <= w_new;
                    r_skid_cnt <= r_skid_cnt + 2'd1;
                end
                2'b01: begin
                    r_skid0    <= r_skid1;
                    r_skid1    <= '0;
                    r_skid_cnt <= r_skid_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_skid_cnt == 2'd1) begin
                        r_skid0 <= w_new;
                    end else begin
                        r_skid0 <= r_skid1;
                        r_skid1 <= w_new;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ifmap_stream_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifmap_stream_feeder
// Description : Self-checking bench for ifmap_stream_feeder against a
//               queue-based model of the expected read and word streams.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifmap_stream_feeder;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [9:0]  base_addr;
    logic [7:0]  row_len;
    logic [7:0]  num_rows;
    logic        busy;
    logic        done;
    logic        mem_ren;
    logic [9:0]  mem_addr;
    logic [15:0] mem_rdata;
    logic        fifo_full;
    logic        fifo_wen;
    logic [17:0] fifo_wdata;

    logic [15:0] mem [0:1023];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Synchronous memory; garbage on idle cycles exposes reads of stale data.
    always @(posedge clk) mem_rdata <= mem_ren ? mem[mem_addr] : 16'($urandom);

    ifmap_stream_feeder dut (
        .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr),
        .row_len(row_len), .num_rows(num_rows), .busy(busy), .done(done),
        .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .fifo_full(fifo_full), .fifo_wen(fifo_wen), .fifo_wdata(fifo_wdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // fmode: 0 never full, 1 full in cycles 4..7, 2 random full
    task automatic run(input logic [9:0] b, input logic [7:0] rl, input logic [7:0] nr,
                       input int fmode, input bit hold, input int exp_first, input int exp_done);
        logic [17:0] exp_w[$];
        logic [9:0]  exp_a[$];
        int n, k, first, done_cyc, writes, reads;
        n = int'(rl) * int'(nr);
        for (int i = 0; i < n; i++) begin
            logic [9:0] a;
            a = 10'(int'(b) + i);
            exp_a.push_back(a);
            exp_w.push_back({i == n - 1, (i % int'(rl)) == int'(rl) - 1, mem[a]});
        end
        @(negedge clk);
        chk("idle_busy", {busy, done}, 2'b00);
        base_addr = b; row_len = rl; num_rows = nr; start = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        k = 0; first = -1; done_cyc = -1; writes = 0; reads = 0;
        while (done_cyc < 0 && k < 300) begin
            k++;
            case (fmode)
                1:       fifo_full = (k >= 4 && k <= 7);
                2:       fifo_full = ($urandom_range(0, 2) == 0);
                default: fifo_full = 1'b0;
            endcase
            @(negedge clk);
            if (k == 1) chk("busy_c1", busy, 1'b1);
            if (mem_ren) begin
                reads++;
                if (exp_a.size() > 0) chk("mem_addr", mem_addr, exp_a.pop_front());
            end
            if (fifo_wen) begin
                writes++;
                if (first < 0) first = k;
                chk("wen_while_full", fifo_full, 1'b0);
                if (exp_w.size() > 0) chk("word", fifo_wdata, exp_w.pop_front());
            end
            if (done) begin
                done_cyc = k;
                chk("busy_at_done", busy, 1'b1);
            end
            @(posedge clk); #1;
        end
        fifo_full = 1'b0;
        chk("done_seen", done_cyc > 0, 1'b1);
        chk("write_count", writes, n);
        chk("read_count", reads, n);
        if (exp_first >= 0) chk("first_write_cycle", first, exp_first);
        if (exp_done >= 0)  chk("done_cycle", done_cyc, exp_done);
    endtask

    initial begin
        int w;
        rstn = 1'b0; start = 1'b0; fifo_full = 1'b0;
        base_addr = '0; row_len = '0; num_rows = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 16'(i);
        #12;
        chk("reset_ctrl", {busy, done, mem_ren, fifo_wen}, 4'b0000);
        chk("reset_addr", mem_addr, 10'h000);
        chk("reset_wdata", fifo_wdata, 18'h0);
        @(negedge clk); rstn = 1'b1;

        run(10'h010, 8'd3, 8'd2, 0, 1'b0, 3, 9);    // basic
        run(10'h010, 8'd3, 8'd2, 1, 1'b0, 3, -1);   // backpressure
        run(10'h000, 8'd0, 8'd5, 0, 1'b0, -1, 2);   // zero row length
        run(10'h020, 8'd4, 8'd0, 0, 1'b0, -1, 2);   // zero rows
        run(10'h3FE, 8'd4, 8'd1, 0, 1'b0, 3, 7);    // address wrap

        // Reset mid-run after two words of a 3x3 tile
        for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
        @(negedge clk);
        base_addr = 10'h040; row_len = 8'd3; num_rows = 8'd3; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        w = 0;
        for (int k = 0; k < 50 && w < 2; k++) begin
            @(negedge clk);
            if (fifo_wen) w++;
        end
        chk("pre_reset_writes", w, 2);
        #2 rstn = 1'b0;
        #1;
        chk("midrst_ctrl", {busy, done, mem_ren, fifo_wen}, 4'b0000);
        chk("midrst_addr", mem_addr, 10'h000);
        chk("midrst_wdata", fifo_wdata, 18'h0);
        @(negedge clk); @(negedge clk); rstn = 1'b1;
        run(10'h100, 8'd3, 8'd3, 0, 1'b0, 3, 12);

        // start held high: second transfer re-arms the cycle after done
        run(10'h200, 8'd2, 8'd2, 0, 1'b1, 3, 7);
        run(10'h200, 8'd2, 8'd2, 0, 1'b0, 3, 7);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("no_extra_run", {busy, mem_ren}, 2'b00);
        end

        // Randomized tiles under random backpressure
        for (int t = 0; t < 8; t++) begin
            run(10'($urandom), 8'($urandom_range(1, 5)), 8'($urandom_range(1, 4)),
                2, 1'b0, -1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
